load_store_unit: RTL



---
 rtl/load_store_unit.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Multi-cycle load/store controller for the 128-word data memory. Sub-word stores
// are done as read-modify-write; sub-word loads are lane-aligned and extended.
module load_store_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        op_store,
    input  logic [1:0]  size,
    input  logic        ld_unsigned,
    input  logic [8:0]  addr,
    input  logic [31:0] st_data,
    input  logic [31:0] mem_rdata,
    output logic        MemRead,
    output logic        MemWrite,
    output logic [8:0]  mem_addr,
    output logic [31:0] mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] ld_result
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RMW_RD = 3'd2,
        S_WR     = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      state_r;
    logic [1:0]  size_r;
    logic [1:0]  lane_r;
    logic        ld_unsigned_r;
    logic [15:0] st_half_r;

    state_t      launch_state_s;
    logic        launch_mis_s;

    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] lane);
        logic res;
        case (sz)
            2'b00:   res = 1'b0;
            2'b01:   res = lane[0];
            2'b10:   res = (lane != 2'b00);
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_align(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   res = {{24{b[7] & ~uns}}, b};
            2'b01:   res = {{16{h[15] & ~uns}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] data,
                                                input logic [1:0] sz, input logic [1:0] lane);
        logic [31:0] res;
        res = word;
        case (sz)
            2'b00:   res[{lane, 3'b000} +: 8] = data[7:0];
            2'b01: begin
                if (lane[1]) begin
                    res[31:16] = data;
                end else begin
                    res[15:0] = data;
                end
            end
            default: res = word;
        endcase
        return res;
    endfunction

    // Decode where a newly accepted request goes; misalignment wins over everything.
    always_comb begin
        launch_state_s = S_IDLE;
        launch_mis_s   = 1'b0;
        if (is_misaligned(size, addr[1:0])) begin
            launch_state_s = S_DONE;
            launch_mis_s   = 1'b1;
        end else if (!op_store) begin
            launch_state_s = S_RD;
        end else if (size == 2'b10) begin
            launch_state_s = S_WR;
        end else begin
            launch_state_s = S_RMW_RD;
        end
    end

    // Sequencer; every output is a register updated on the transition into its state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= S_IDLE;
            size_r        <= 2'b00;
            lane_r        <= 2'b00;
            ld_unsigned_r <= 1'b0;
            st_half_r     <= 16'h0000;
            MemRead       <= 1'b0;
            MemWrite      <= 1'b0;
            mem_addr      <= 9'h000;
            mem_wdata     <= 32'h0000_0000;
            busy          <= 1'b0;
            done          <= 1'b0;
            misaligned    <= 1'b0;
            ld_result     <= 32'h0000_0000;
        end else begin
            case (state_r)
                // DONE accepts a new request on its way out, giving back-to-back throughput.
                S_IDLE, S_DONE: begin
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                    if (start) begin
                        state_r       <= launch_state_s;
                        size_r        <= size;
                        lane_r        <= addr[1:0];
                        ld_unsigned_r <= ld_unsigned;
                        st_half_r     <= st_data[15:0];
                        busy          <= 1'b1;
                        MemRead       <= (launch_state_s == S_RD) || (launch_state_s == S_RMW_RD);
                        MemWrite      <= (launch_state_s == S_WR);
                        if (launch_mis_s) begin
                            done       <= 1'b1;
                            misaligned <= 1'b1;
                        end else begin
                            mem_addr <= {addr[8:2], 2'b00};
                        end
                        if (launch_state_s == S_WR) begin
                            mem_wdata <= st_data;
                        end else begin
                            mem_wdata <= mem_wdata;
                        end
                    end else begin
                        state_r  <= S_IDLE;
                        busy     <= 1'b0;
                        MemRead  <= 1'b0;
                        MemWrite <= 1'b0;
                    end
                end
                S_RD: begin
                    ld_result <= load_align(mem_rdata, size_r, lane_r, ld_unsigned_r);
                    MemRead   <= 1'b0;
                    done      <= 1'b1;
                    state_r   <= S_DONE;
                end
                S_RMW_RD: begin
                    mem_wdata <= store_merge(mem_rdata, st_half_r, size_r, lane_r);
                    MemRead   <= 1'b0;
                    MemWrite  <= 1'b1;
                    state_r   <= S_WR;
                end
                S_WR: begin
                    MemWrite <= 1'b0;
                    done     <= 1'b1;
                    state_r  <= S_DONE;
                end
                default: begin
                    state_r    <= S_IDLE;
                    MemRead    <= 1'b0;
                    MemWrite   <= 1'b0;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                    misaligned <= 1'b0;
                end
            endcase
        end
    end

endmodule
